// File: rtl/gpr_wb_arb_pkg.sv
// Shared types for the GPR writeback arbiter: JTAG FSM states, write-source
// select encoding and default widths.
package gpr_arb_pkg;

  localparam int unsigned GPR_DATA_WIDTH = 32;
  localparam int unsigned GPR_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    J_IDLE,
    J_ARB,
    J_ACC,
    J_DONE
  } jtag_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_EX,
    SEL_LSU_BYP,
    SEL_LSU_BUF,
    SEL_JTAG
  } wsel_e;

endpackage

// File: rtl/gpr_wb_arb_if.sv
// Bundle of every writeback, decode, debug and register-file signal around
// the arbiter; slave is the arbiter side, master the surrounding core.
interface gpr_wb_arb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  ex_wb_valid;
  logic [ADDR_WIDTH-1:0] ex_wb_addr;
  logic [DATA_WIDTH-1:0] ex_wb_data;
  logic                  lsu_wb_valid;
  logic [ADDR_WIDTH-1:0] lsu_wb_addr;
  logic [DATA_WIDTH-1:0] lsu_wb_data;
  logic                  lsu_wb_ready;
  logic                  lsu_issue_valid;
  logic [ADDR_WIDTH-1:0] lsu_issue_rd;
  logic [ADDR_WIDTH-1:0] dec_rs1_addr;
  logic [ADDR_WIDTH-1:0] dec_rs2_addr;
  logic [ADDR_WIDTH-1:0] dec_rd_addr;
  logic                  hazard_stall;
  logic                  jtag_req;
  logic                  jtag_we;
  logic [ADDR_WIDTH-1:0] jtag_addr;
  logic [DATA_WIDTH-1:0] jtag_wdata;
  logic                  jtag_ack;
  logic [DATA_WIDTH-1:0] jtag_rdata;
  logic                  gpr_we;
  logic [ADDR_WIDTH-1:0] gpr_waddr;
  logic [DATA_WIDTH-1:0] gpr_wdata;
  logic [ADDR_WIDTH-1:0] gpr_raddr;
  logic [DATA_WIDTH-1:0] gpr_rdata;

  modport slave (
    input  ex_wb_valid, ex_wb_addr, ex_wb_data,
    input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
    output lsu_wb_ready,
    input  lsu_issue_valid, lsu_issue_rd,
    input  dec_rs1_addr, dec_rs2_addr, dec_rd_addr,
    output hazard_stall,
    input  jtag_req, jtag_we, jtag_addr, jtag_wdata,
    output jtag_ack, jtag_rdata,
    output gpr_we, gpr_waddr, gpr_wdata, gpr_raddr,
    input  gpr_rdata
  );

  modport master (
    output ex_wb_valid, ex_wb_addr, ex_wb_data,
    output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
    input  lsu_wb_ready,
    output lsu_issue_valid, lsu_issue_rd,
    output dec_rs1_addr, dec_rs2_addr, dec_rd_addr,
    input  hazard_stall,
    output jtag_req, jtag_we, jtag_addr, jtag_wdata,
    input  jtag_ack, jtag_rdata,
    input  gpr_we, gpr_waddr, gpr_wdata, gpr_raddr,
    output gpr_rdata
  );
endinterface

// File: rtl/gpr_scoreboard.sv
// One busy bit per GPR tracking outstanding loads; register 0 is never busy.
module gpr_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  busy_rd,
  output logic                  all_clear,
  input  logic                  chk_valid,
  input  logic [ADDR_WIDTH-1:0] chk_addr
);
  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

  logic [NREGS-1:0] busy, busy_next;

  // Set is applied after clear so a same-cycle issue to a committing rd wins.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign busy_rs1  = busy[rs1_addr];
  assign busy_rs2  = busy[rs2_addr];
  assign busy_rd   = busy[rd_addr];
  assign all_clear = (busy == '0);

  always_ff @(posedge clk) begin
    if (!rst && chk_valid)
      assert (!busy[chk_addr])
        else $error("WAW: ex writeback to outstanding load rd %0d", chk_addr);
  end
endmodule

// File: rtl/gpr_wb_arb.sv
// GPR write-port arbiter: ex > LSU (skid buffer, then bypass) > JTAG, with
// load scoreboard, decode hazard stall and a four-phase JTAG access FSM.
module gpr_wb_arb
  import gpr_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH
) (
  input logic         clk,
  input logic         rst,
  gpr_wb_arb_if.slave bus
);
  jtag_state_e state, state_next;
  wsel_e       sel;

  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  lsu_accept;
  logic                  busy_rs1, busy_rs2, busy_rd, all_clear;
  logic                  lsu_commit;
  logic [ADDR_WIDTH-1:0] commit_addr;

  // Everything except ex is masked while rst is high so nothing but ex can
  // write during reset, and buffered data is dropped rather than drained.
  assign bus.lsu_wb_ready = rst | ~buf_valid;
  assign lsu_accept       = bus.lsu_wb_valid & ~buf_valid & ~rst;

  always_comb begin
    sel           = SEL_NONE;
    bus.gpr_waddr = '0;
    bus.gpr_wdata = '0;
    if (bus.ex_wb_valid) begin
      sel           = SEL_EX;
      bus.gpr_waddr = bus.ex_wb_addr;
      bus.gpr_wdata = bus.ex_wb_data;
    end else if (buf_valid && !rst) begin
      sel           = SEL_LSU_BUF;
      bus.gpr_waddr = buf_addr;
      bus.gpr_wdata = buf_data;
    end else if (lsu_accept) begin
      sel           = SEL_LSU_BYP;
      bus.gpr_waddr = bus.lsu_wb_addr;
      bus.gpr_wdata = bus.lsu_wb_data;
    end else if (state == J_ACC && bus.jtag_we && !rst) begin
      sel           = SEL_JTAG;
      bus.gpr_waddr = bus.jtag_addr;
      bus.gpr_wdata = bus.jtag_wdata;
    end
  end

  assign bus.gpr_we    = (sel != SEL_NONE) && (bus.gpr_waddr != '0);
  assign bus.gpr_raddr = bus.jtag_addr;
  assign lsu_commit    = (sel == SEL_LSU_BUF) || (sel == SEL_LSU_BYP);
  assign commit_addr   = (sel == SEL_LSU_BUF) ? buf_addr : bus.lsu_wb_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (lsu_accept && bus.ex_wb_valid) begin
      buf_valid <= 1'b1;
      buf_addr  <= bus.lsu_wb_addr;
      buf_data  <= bus.lsu_wb_data;
    end else if (sel == SEL_LSU_BUF) begin
      buf_valid <= 1'b0;
    end
  end

  gpr_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (bus.lsu_issue_valid),
    .set_addr  (bus.lsu_issue_rd),
    .clr_en    (lsu_commit),
    .clr_addr  (commit_addr),
    .rs1_addr  (bus.dec_rs1_addr),
    .rs2_addr  (bus.dec_rs2_addr),
    .rd_addr   (bus.dec_rd_addr),
    .busy_rs1  (busy_rs1),
    .busy_rs2  (busy_rs2),
    .busy_rd   (busy_rd),
    .all_clear (all_clear),
    .chk_valid (bus.ex_wb_valid),
    .chk_addr  (bus.ex_wb_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= J_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      J_IDLE: if (bus.jtag_req) state_next = J_ARB;
      J_ARB:  if (!bus.ex_wb_valid && !buf_valid && !bus.lsu_wb_valid && all_clear)
                state_next = J_ACC;
      J_ACC:  state_next = J_DONE;
      J_DONE: if (!bus.jtag_req) state_next = J_IDLE;
      default: state_next = J_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                  bus.jtag_rdata <= '0;
    else if (state == J_ACC && !bus.jtag_we)  bus.jtag_rdata <= bus.gpr_rdata;
  end

  assign bus.jtag_ack     = (state == J_DONE);
  assign bus.hazard_stall = ~rst & (busy_rs1 | busy_rs2 | busy_rd |
                                    (state == J_ARB) | (state == J_ACC));
endmodule

// File: tb/tb_gpr_wb_arb.sv
// Directed self-checking bench for gpr_wb_arb: inputs change just after the
// falling edge, outputs are checked 1ns later, state advances on the rising edge.
module tb_gpr_wb_arb;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  gpr_wb_arb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  gpr_wb_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.gpr_rdata = rf[bus.gpr_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ex_wb_valid = 0;      bus.ex_wb_addr = '0;  bus.ex_wb_data = '0;
    bus.lsu_wb_valid = 0;     bus.lsu_wb_addr = '0; bus.lsu_wb_data = '0;
    bus.lsu_issue_valid = 0;  bus.lsu_issue_rd = '0;
    bus.dec_rs1_addr = '0;    bus.dec_rs2_addr = '0; bus.dec_rd_addr = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[9] = 32'hCAFE;
    rst = 1;
    idle_inputs();
    bus.jtag_req = 0; bus.jtag_we = 0; bus.jtag_addr = '0; bus.jtag_wdata = '0;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_ready", bus.lsu_wb_ready, 1);
    chk("rst_stall", bus.hazard_stall, 0);
    chk("rst_we",    bus.gpr_we, 0);
    chk("rst_ack",   bus.jtag_ack, 0);
    chk("rst_rdata", bus.jtag_rdata, 0);

    // ex writeback is combinational; address 0 suppressed
    cyc(); rst = 0;
    bus.ex_wb_valid = 1; bus.ex_wb_addr = 5; bus.ex_wb_data = 32'h1234; #1;
    chk("ex_we",    bus.gpr_we, 1);
    chk("ex_waddr", bus.gpr_waddr, 5);
    chk("ex_wdata", bus.gpr_wdata, 32'h1234);
    cyc(); bus.ex_wb_addr = 0; bus.ex_wb_data = 32'hDEAD; #1;
    chk("ex_a0_we", bus.gpr_we, 0);

    // Load to r7, hazard, buffered return under ex, drain when ex idles
    cyc(); idle_inputs(); bus.lsu_issue_valid = 1; bus.lsu_issue_rd = 7;
    cyc(); idle_inputs(); bus.dec_rs1_addr = 7; #1;
    chk("ld7_stall", bus.hazard_stall, 1);
    bus.ex_wb_valid = 1; bus.ex_wb_addr = 2; bus.ex_wb_data = 32'h22;
    bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 7; bus.lsu_wb_data = 32'hAAAA; #1;
    chk("ld7_exwins", bus.gpr_waddr, 2);
    chk("ld7_rdy0",   bus.lsu_wb_ready, 1);
    cyc(); idle_inputs(); bus.dec_rs1_addr = 7; #1;
    chk("buf_ready",  bus.lsu_wb_ready, 0);
    chk("buf_we",     bus.gpr_we, 1);
    chk("buf_waddr",  bus.gpr_waddr, 7);
    chk("buf_wdata",  bus.gpr_wdata, 32'hAAAA);
    chk("buf_stall",  bus.hazard_stall, 1);
    cyc(); #1;
    chk("drn_stall",  bus.hazard_stall, 0);
    chk("drn_ready",  bus.lsu_wb_ready, 1);
    chk("drn_we",     bus.gpr_we, 0);

    // Same-cycle issue and bypass commit of r3: busy stays set
    cyc(); idle_inputs(); bus.lsu_issue_valid = 1; bus.lsu_issue_rd = 3;
    cyc(); idle_inputs(); bus.lsu_issue_valid = 1; bus.lsu_issue_rd = 3;
    bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 3; bus.lsu_wb_data = 32'h33; #1;
    chk("byp_we",    bus.gpr_we, 1);
    chk("byp_waddr", bus.gpr_waddr, 3);
    chk("byp_wdata", bus.gpr_wdata, 32'h33);
    cyc(); idle_inputs(); bus.dec_rs2_addr = 3; #1;
    chk("setwin_rs2", bus.hazard_stall, 1);
    bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 3; bus.lsu_wb_data = 32'h34;
    cyc(); idle_inputs(); bus.dec_rd_addr = 3; #1;
    chk("clr3_rd", bus.hazard_stall, 0);

    // JTAG read of r9 held in ARB until the r6 load commits
    cyc(); idle_inputs(); bus.lsu_issue_valid = 1; bus.lsu_issue_rd = 6;
    cyc(); idle_inputs(); bus.jtag_req = 1; bus.jtag_we = 0; bus.jtag_addr = 9;
    cyc(); #1;
    chk("arb_stall", bus.hazard_stall, 1);
    chk("arb_ack",   bus.jtag_ack, 0);
    cyc(); cyc(); #1;
    chk("arb_hold_stall", bus.hazard_stall, 1);
    chk("arb_hold_ack",   bus.jtag_ack, 0);
    bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 6; bus.lsu_wb_data = 32'h66; #1;
    chk("arb_ld_waddr", bus.gpr_waddr, 6);
    cyc(); bus.lsu_wb_valid = 0; #1;
    chk("arb_last_ack", bus.jtag_ack, 0);
    cyc(); #1;
    chk("acc_stall", bus.hazard_stall, 1);
    chk("acc_raddr", bus.gpr_raddr, 9);
    chk("acc_we",    bus.gpr_we, 0);
    cyc(); #1;
    chk("done_ack",   bus.jtag_ack, 1);
    chk("done_rdata", bus.jtag_rdata, 32'hCAFE);
    chk("done_stall", bus.hazard_stall, 0);
    cyc(); #1;
    chk("done_hold", bus.jtag_ack, 1);
    bus.jtag_req = 0;
    cyc(); #1;
    chk("ack_drop", bus.jtag_ack, 0);

    // JTAG writes: r10 goes through, r0 is suppressed but still acked
    cyc(); bus.jtag_req = 1; bus.jtag_we = 1; bus.jtag_addr = 10; bus.jtag_wdata = 32'h5A5A;
    cyc(); cyc(); #1;
    chk("jw_we",    bus.gpr_we, 1);
    chk("jw_waddr", bus.gpr_waddr, 10);
    chk("jw_wdata", bus.gpr_wdata, 32'h5A5A);
    cyc(); #1;
    chk("jw_ack", bus.jtag_ack, 1);
    bus.jtag_req = 0;
    cyc(); bus.jtag_req = 1; bus.jtag_addr = 0; bus.jtag_wdata = 32'hFFFF_FFFF;
    cyc(); cyc(); #1;
    chk("jw0_we",    bus.gpr_we, 0);
    chk("jw0_stall", bus.hazard_stall, 1);
    cyc(); #1;
    chk("jw0_ack", bus.jtag_ack, 1);
    bus.jtag_req = 0;
    cyc(); #1;
    chk("jw0_ackdrop", bus.jtag_ack, 0);

    // Reset while in ARB (held by outstanding r8) abandons the write
    cyc(); bus.lsu_issue_valid = 1; bus.lsu_issue_rd = 8;
    cyc(); idle_inputs(); bus.jtag_req = 1; bus.jtag_we = 1; bus.jtag_addr = 12; bus.jtag_wdata = 32'h77;
    cyc(); #1;
    chk("rarb_stall", bus.hazard_stall, 1);
    rst = 1; bus.jtag_req = 0;
    cyc(); #1;
    chk("rarb_ack",   bus.jtag_ack, 0);
    chk("rarb_stall2", bus.hazard_stall, 0);
    chk("rarb_we",    bus.gpr_we, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("post_rst_we",  bus.gpr_we, 0);
      chk("post_rst_ack", bus.jtag_ack, 0);
    end

    // Reset with a full buffer discards it
    cyc(); bus.ex_wb_valid = 1; bus.ex_wb_addr = 2; bus.ex_wb_data = 32'h2;
    bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 13; bus.lsu_wb_data = 32'hBEEF;
    cyc(); idle_inputs(); rst = 1; #1;
    chk("rbuf_we",    bus.gpr_we, 0);
    chk("rbuf_ready", bus.lsu_wb_ready, 1);
    cyc(); rst = 0; #1;
    chk("rbuf_we2",    bus.gpr_we, 0);
    chk("rbuf_ready2", bus.lsu_wb_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
